memory_arbiter: RTL
===================

Name: memory_arbiter

Overview:
Responder side of the cache-to-memory request interface. Accepts instruction-fetch requests (iREN/iaddr) and data requests (dREN/dWEN/daddr/dstore) from CPUS cores' caches, and serialises them onto the single RAM port. Returns data and releases the per-requester wait signals. Sits between the per-core caches and the RAM model, one level above RAM in the memory hierarchy.

Parameters:
CPUS, 2, number of cores. Each core has one instruction and one data requester. Range 1..4.

Ports:
CLK  in  1  system clock, rising edge
nRST  in  1  asynchronous active-low reset
iREN  in  CPUS  instruction read request per core
iaddr  in  CPUS x 32  instruction address per core (word_t)
iwait  out  CPUS  instruction wait per core; 0 = iload valid this cycle
iload  out  CPUS x 32  instruction data per core
dREN  in  CPUS  data read request per core
dWEN  in  CPUS  data write request per core
daddr  in  CPUS x 32  data address per core
dstore  in  CPUS x 32  data write value per core
dwait  out  CPUS  data wait per core; 0 = access complete this cycle
dload  out  CPUS x 32  data read value per core
ramREN  out  1  RAM read enable
ramWEN  out  1  RAM write enable
ramaddr  out  32  RAM address
ramstore  out  32  RAM write data
ramload  in  32  RAM read data
ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR

Behaviour:
- Reset (async, nRST=0): state=IDLE, rr=0, all iwait/dwait=1, iload/dload=0, ramREN=ramWEN=0, ramaddr=ramstore=0. Reset mid-access abandons the access silently. No wait is released.
- FSM states: IDLE, SERVE.
- IDLE: the block drives no RAM enables. If any request is pending, it latches the grant (gcore, gtype in {DWRITE, DREAD, IREAD}) and moves to SERVE next cycle. Otherwise it stays in IDLE.
- Selection order, fixed: data before instruction.
  - Data pass: scan cores rr, rr+1, ... mod CPUS; the first core with dWEN|dREN wins. dWEN beats dREN if both are set (write wins).
  - Instruction pass: runs only if no data request exists. Same scan from rr over iREN.
- SERVE, combinational RAM drive from the granted requester's live inputs:
  - DWRITE: ramWEN=1, ramaddr=daddr[g], ramstore=dstore[g].
  - DREAD: ramREN=1, ramaddr=daddr[g].
  - IREAD: ramREN=1, ramaddr=iaddr[g].
  - Requesters hold address and data stable while their wait is 1.
- SERVE completion: when ramstate==ACCESS, the granted wait goes 0 for exactly that cycle.
  - For a read, the granted load output = ramload that cycle.
  - Next state=IDLE. rr <= (gcore+1) mod CPUS.
- SERVE with ramstate FREE/BUSY: hold. ERROR: hold and keep re-driving the request (retry); no wait is released.
- Cancel: if the granted request's enable drops in SERVE before ACCESS (e.g. REN dropped, or DWRITE's dWEN dropped), return to IDLE with no wait released and rr unchanged.
- All non-granted waits stay 1. Loads of non-granted requesters are 0.
- Minimum latency: request seen in IDLE at cycle t, RAM enables at t+1, earliest wait release at t+1 if RAM answers ACCESS immediately. There is a mandatory IDLE bubble between back-to-back grants.
- Simultaneous dREN and dWEN on one core is a protocol violation; it is handled as a write.
- Address is passed through unmodified; no alignment check.

Decomposition:
- Shared types package (existing cpu_types_pkg) carries:
  - word_t (32-bit)
  - ramstate_t {FREE, BUSY, ACCESS, ERROR}
  - new grant_t {DWRITE, DREAD, IREAD}
- Sub-module mem_grant_sel: combinational selector. Inputs are the request vectors and rr; outputs are valid, core index and grant_t. It is verified standalone for the priority/round-robin rules.

Test Plan:
1. Reset with iREN[0]=1 asserted -> iwait=all 1, ramREN=0 during reset. After release, ramREN=1 with ramaddr=iaddr[0]=0x0000_0040 at cycle t+1.
2. Core0 iREN and core1 dREN both raised at the same cycle, RAM ACCESS after 2 BUSY cycles -> core1 served first. dwait[1]=0 for one cycle with dload[1]=ramload=0xDEAD_BEEF. IDLE bubble follows, then core0 fetch is served.
3. Both cores hold dWEN continuously, rr=0 -> grants alternate 0,1,0,1. ramstore matches each core's dstore (0x11, 0x22).
4. dREN[0] and dWEN[0] both 1 -> ramWEN=1, ramREN=0, dwait[0]=0 on ACCESS.
5. ramstate=ERROR for 3 cycles, then ACCESS -> request is held and re-driven throughout. Exactly one wait pulse on ACCESS.
6. nRST asserted while in SERVE with ramstate=BUSY, and iREN[1] dropped mid-SERVE in a separate run -> both return to IDLE with no wait pulse. The cancel case leaves rr unchanged.

Source files
------------

// File: rtl/memory_arbiter_pkg.sv
// Shared types for the cache-to-memory arbiter: word, RAM status, grant kind, FSM state.
// Ports: none (package).
// Latency/backpressure: not applicable.
package memory_arbiter_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    DWRITE = 2'd0,
    DREAD  = 2'd1,
    IREAD  = 2'd2
  } grant_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } arb_state_t;

  // Width of a core index; a single-core build still needs a 1-bit field.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/memory_arbiter_if.sv
// Bundle of per-core cache request/response signals plus the single RAM port.
// Ports: slave = arbiter side (takes requests, drives RAM); master = caches + RAM model side.
// Latency/backpressure: wires only; iwait/dwait are the per-requester stall signals.
interface memory_arbiter_if #(
  parameter int CPUS = 2
);
  import memory_arbiter_pkg::*;

  logic [CPUS-1:0]  iREN;
  word_t [CPUS-1:0] iaddr;
  logic [CPUS-1:0]  iwait;
  word_t [CPUS-1:0] iload;
  logic [CPUS-1:0]  dREN;
  logic [CPUS-1:0]  dWEN;
  word_t [CPUS-1:0] daddr;
  word_t [CPUS-1:0] dstore;
  logic [CPUS-1:0]  dwait;
  word_t [CPUS-1:0] dload;
  logic             ramREN;
  logic             ramWEN;
  word_t            ramaddr;
  word_t            ramstore;
  word_t            ramload;
  ramstate_t        ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/memory_arbiter_grant_sel.sv
// Combinational grant selector: data before instruction, round-robin from rr, write beats read.
// Ports: iren/dren/dwen request vectors, rr scan start -> vld, core index, grant kind.
// Latency: zero (pure combinational); no backpressure.
module mem_grant_sel
  import memory_arbiter_pkg::*;
#(
  parameter int CPUS  = 2,
  parameter int IDX_W = idx_w(CPUS)
) (
  input  logic [CPUS-1:0]  iren,
  input  logic [CPUS-1:0]  dren,
  input  logic [CPUS-1:0]  dwen,
  input  logic [IDX_W-1:0] rr,
  output logic             vld,
  output logic [IDX_W-1:0] core,
  output grant_t           gtype
);

  logic             d_vld;
  logic             d_wr;
  logic [IDX_W-1:0] d_core;
  logic             i_vld;
  logic [IDX_W-1:0] i_core;
  int               idx;

  // Scan in reverse order so the last hit assigned is the first core from rr.
  always_comb begin
    d_vld  = 1'b0;
    d_wr   = 1'b0;
    d_core = '0;
    i_vld  = 1'b0;
    i_core = '0;
    idx    = 0;
    for (int k = CPUS - 1; k >= 0; k--) begin
      idx = (int'(rr) + k) % CPUS;
      if (dwen[idx] || dren[idx]) begin
        d_vld  = 1'b1;
        d_core = IDX_W'(idx);
        d_wr   = dwen[idx];
      end
      if (iren[idx]) begin
        i_vld  = 1'b1;
        i_core = IDX_W'(idx);
      end
    end
  end

  always_comb begin
    vld   = d_vld || i_vld;
    core  = d_vld ? d_core : i_core;
    gtype = d_vld ? (d_wr ? DWRITE : DREAD) : IREAD;
  end

endmodule

// File: rtl/memory_arbiter.sv
// Serialises per-core instruction/data requests onto one RAM port, releasing waits on ACCESS.
// Ports: CLK, nRST (async active-low), bus = slave side of memory_arbiter_if.
// Latency: grant latched in IDLE, RAM driven next cycle; waits stay high until RAM ACCESS.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int CPUS = 2
) (
  input  logic              CLK,
  input  logic              nRST,
  memory_arbiter_if.slave   bus
);

  localparam int IDX_W = idx_w(CPUS);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] gcore_q, gcore_d;
  grant_t           gtype_q, gtype_d;
  logic [IDX_W-1:0] rr_q, rr_d;

  logic             sel_vld;
  logic [IDX_W-1:0] sel_core;
  grant_t           sel_type;
  logic             g_live;
  logic             g_done;

  mem_grant_sel #(.CPUS(CPUS), .IDX_W(IDX_W)) u_sel (
    .iren  (bus.iREN),
    .dren  (bus.dREN),
    .dwen  (bus.dWEN),
    .rr    (rr_q),
    .vld   (sel_vld),
    .core  (sel_core),
    .gtype (sel_type)
  );

  // The granted requester's own enable must still be up; if it drops the access is cancelled.
  always_comb begin
    g_live = 1'b0;
    case (gtype_q)
      DWRITE:  g_live = bus.dWEN[gcore_q];
      DREAD:   g_live = bus.dREN[gcore_q];
      default: g_live = bus.iREN[gcore_q];
    endcase
    g_done = (state_q == SERVE) && g_live && (bus.ramstate == ACCESS);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      gcore_q <= '0;
      gtype_q <= IREAD;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      gcore_q <= gcore_d;
      gtype_q <= gtype_d;
      rr_q    <= rr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gcore_d = gcore_q;
    gtype_d = gtype_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: begin
        if (sel_vld) begin
          state_d = SERVE;
          gcore_d = sel_core;
          gtype_d = sel_type;
        end
      end
      default: begin
        if (!g_live) begin
          state_d = IDLE;
        end else if (g_done) begin
          state_d = IDLE;
          rr_d    = IDX_W'((int'(gcore_q) + 1) % CPUS);
        end
      end
    endcase
  end

  // RAM drive follows the granted requester's live inputs; ERROR simply keeps re-driving.
  always_comb begin
    bus.iwait    = '1;
    bus.dwait    = '1;
    bus.iload    = '0;
    bus.dload    = '0;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    if (state_q == SERVE && g_live) begin
      case (gtype_q)
        DWRITE: begin
          bus.ramWEN   = 1'b1;
          bus.ramaddr  = bus.daddr[gcore_q];
          bus.ramstore = bus.dstore[gcore_q];
          if (g_done) bus.dwait[gcore_q] = 1'b0;
        end
        DREAD: begin
          bus.ramREN  = 1'b1;
          bus.ramaddr = bus.daddr[gcore_q];
          if (g_done) begin
            bus.dwait[gcore_q] = 1'b0;
            bus.dload[gcore_q] = bus.ramload;
          end
        end
        default: begin
          bus.ramREN  = 1'b1;
          bus.ramaddr = bus.iaddr[gcore_q];
          if (g_done) begin
            bus.iwait[gcore_q] = 1'b0;
            bus.iload[gcore_q] = bus.ramload;
          end
        end
      endcase
    end
  end

endmodule
